// File: rtl/spi_frame_assembler_pkg.sv
// Shared types and constants for the SPI transmit frame assembler.
package abae_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    HOLD
  } frame_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BAD_LEN = 2'b10;

  function automatic int unsigned msg_bytes(input int unsigned message_size);
    return message_size / 8;
  endfunction

  function automatic int unsigned hdr_bytes(input int unsigned header_size);
    return header_size / 8;
  endfunction

endpackage

// File: rtl/spi_frame_assembler_gap_timer.sv
// Inter-byte gap timer: flags the idle cycle on which the gap limit is reached.
module frame_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Expiry is flagged on the idle edge that would bring the count to the limit.
  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_frame_assembler.sv
// Packs a UART byte stream into a header + message frame and hands it to the
// SPI controller over valid/ready; bad lengths and stalled frames are dropped.
module spi_frame_assembler
  import abae_frame_pkg::*;
#(
  parameter int unsigned MESSAGE_SIZE   = 512,
  parameter int unsigned HEADER_SIZE    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid_in,
  output logic                    byte_ready_out,
  output logic [HEADER_SIZE-1:0]  tx_header_out,
  output logic [MESSAGE_SIZE-1:0] tx_message_out,
  output logic                    tx_valid_out,
  input  logic                    tx_ready_in,
  output logic                    error_out,
  output logic [1:0]              error_code_out
);

  localparam int unsigned MSG_BYTES = msg_bytes(MESSAGE_SIZE);
  localparam int unsigned HDR_BYTES = hdr_bytes(HEADER_SIZE);
  localparam int unsigned PAY_W     = $clog2(MSG_BYTES + 1);
  localparam int unsigned HDR_W     = $clog2(HDR_BYTES + 1);
  localparam logic [15:0]      MAX_LEN  = 16'(MSG_BYTES);
  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HDR_BYTES - 1);

  frame_state_t state, state_next;

  logic [HEADER_SIZE-1:0]  header;
  logic [MESSAGE_SIZE-1:0] message;
  logic [HDR_W-1:0]        hdr_idx;
  logic [PAY_W-1:0]        pay_idx;
  logic [15:0]             len_q;
  logic [15:0]             len_now;
  logic                    tx_valid;
  logic                    error;
  logic [1:0]              error_code;
  logic                    err_set;
  logic [1:0]              err_code_next;
  logic                    accept;
  logic                    timing;
  logic                    len_check;
  logic                    pay_last;
  logic                    expired;

  assign byte_ready_out = (state != HOLD);
  assign accept         = byte_valid_in && byte_ready_out;
  assign timing         = (state == HEADER) || (state == PAYLOAD);
  assign len_check      = accept && (((state == HEADER) && (hdr_idx == HDR_LAST)) ||
                                     ((state == IDLE) && (HDR_BYTES == 1)));
  assign pay_last       = (state == PAYLOAD) && ((16'(pay_idx) + 16'd1) == len_q);

  // Length is taken with the byte being accepted on this edge as its low byte.
  generate
    if (HDR_BYTES >= 2) begin : g_len_wide
      assign len_now = {header[15:8], byte_in};
    end else begin : g_len_byte
      assign len_now = {8'h00, byte_in};
    end
  endgenerate

  frame_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .clear  (accept || !timing),
    .enable (timing && !accept),
    .expired(expired)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The length decision overrides the per-state transition on the last header byte.
  always_comb begin
    state_next    = state;
    err_set       = 1'b0;
    err_code_next = ERR_NONE;
    unique case (state)
      IDLE:    if (accept) state_next = HEADER;
      HEADER: begin
        if (expired) begin
          state_next    = IDLE;
          err_set       = 1'b1;
          err_code_next = ERR_TIMEOUT;
        end
      end
      PAYLOAD: begin
        if (accept && pay_last) begin
          state_next = HOLD;
        end else if (expired) begin
          state_next    = IDLE;
          err_set       = 1'b1;
          err_code_next = ERR_TIMEOUT;
        end
      end
      HOLD:    if (tx_ready_in) state_next = IDLE;
    endcase
    if (len_check) begin
      if (len_now == 16'd0) begin
        state_next = HOLD;
      end else if (len_now > MAX_LEN) begin
        state_next    = IDLE;
        err_set       = 1'b1;
        err_code_next = ERR_BAD_LEN;
      end else begin
        state_next = PAYLOAD;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_valid   <= 1'b0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
    end else begin
      tx_valid <= (state_next == HOLD);
      error    <= err_set;
      if (err_set) error_code <= err_code_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      header  <= '0;
      message <= '0;
      hdr_idx <= '0;
      pay_idx <= '0;
      len_q   <= '0;
    end else if (accept) begin
      if (len_check) len_q <= len_now;
      unique case (state)
        IDLE: begin
          message                       <= '0;
          header                        <= '0;
          header[HEADER_SIZE-1 -: 8]    <= byte_in;
          hdr_idx                       <= HDR_W'(1);
          pay_idx                       <= '0;
        end
        HEADER: begin
          for (int unsigned k = 1; k < HDR_BYTES; k++) begin
            if (hdr_idx == HDR_W'(k)) header[HEADER_SIZE-1-8*k -: 8] <= byte_in;
          end
          hdr_idx <= hdr_idx + HDR_W'(1);
        end
        PAYLOAD: begin
          for (int unsigned k = 0; k < MSG_BYTES; k++) begin
            if (pay_idx == PAY_W'(k)) message[MESSAGE_SIZE-1-8*k -: 8] <= byte_in;
          end
          pay_idx <= pay_idx + PAY_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign tx_header_out  = header;
  assign tx_message_out = message;
  assign tx_valid_out   = tx_valid;
  assign error_out      = error;
  assign error_code_out = error_code;

endmodule
